// File: rtl/mem_stage_ctl.sv
// mem_stage_ctl: memory-stage controller and MEM/WB pipeline register.
// Issues one-cycle read/write strobes to a variable-latency data memory,
// freezes the upstream pipeline while an access is outstanding, and
// registers the retiring instruction into the MEM/WB fields.
module mem_stage_ctl (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ALUOut_EM,
   input  logic [15:0] R2Data_EM,
   input  logic        memReadEnable_EM,
   input  logic        memWriteEnable_EM,
   input  logic [1:0]  regWriteDataSel_EM,
   input  logic [2:0]  regWriteNum_EM,
   input  logic        regWriteEnable_EM,
   input  logic [15:0] PC2_EM,
   input  logic        halt_EM,
   input  logic        nop_EM,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   input  logic        mem_stall,
   output logic        stall_out,
   output logic [15:0] ALUOut_MW,
   output logic [15:0] memData_MW,
   output logic [15:0] PC2_MW,
   output logic [1:0]  regWriteDataSel_MW,
   output logic [2:0]  regWriteNum_MW,
   output logic        regWriteEnable_MW,
   output logic        halt_MW,
   output logic        nop_MW,
   output logic        err_MW
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state, state_next;

   logic access;
   logic illegal;
   logic legal;
   logic retire;
   logic stall_int;
   logic rd_int;
   logic wr_int;

   assign access   = (memReadEnable_EM | memWriteEnable_EM) & ~nop_EM & ~halt_EM;
   assign illegal  = access & (ALUOut_EM[0] | (memReadEnable_EM & memWriteEnable_EM));
   assign legal    = access & ~illegal;

   assign mem_addr  = ALUOut_EM;
   assign mem_wdata = R2Data_EM;

   // Request strobes and stall are suppressed while reset is held so a
   // reset cycle never launches an access or freezes the pipeline.
   assign mem_rd    = rd_int & ~rst;
   assign mem_wr    = wr_int & ~rst;
   assign stall_out = stall_int & ~rst;

   // State register; reset always returns to IDLE, dropping any pending access.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state, strobes, stall and retire decision for the current cycle.
   always_comb begin
      state_next = state;
      rd_int     = 1'b0;
      wr_int     = 1'b0;
      stall_int  = 1'b0;
      retire     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!legal) begin
               retire = 1'b1;
               if (halt_EM && !nop_EM) state_next = HALTED;
            end else if (mem_stall) begin
               stall_int = 1'b1;
            end else begin
               rd_int = memReadEnable_EM;
               wr_int = memWriteEnable_EM;
               if (mem_done) begin
                  retire = 1'b1;
               end else begin
                  stall_int  = 1'b1;
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_done) begin
               retire     = 1'b1;
               state_next = IDLE;
            end else begin
               stall_int = 1'b1;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // MEM/WB register: load on retire, bubble on stall, freeze once halted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ALUOut_MW          <= 16'h0000;
         memData_MW         <= 16'h0000;
         PC2_MW             <= 16'h0000;
         regWriteDataSel_MW <= 2'b00;
         regWriteNum_MW     <= 3'b000;
         regWriteEnable_MW  <= 1'b0;
         halt_MW            <= 1'b0;
         nop_MW             <= 1'b1;
         err_MW             <= 1'b0;
      end else if (state == HALTED) begin
         halt_MW <= 1'b1;
      end else if (retire) begin
         ALUOut_MW          <= ALUOut_EM;
         memData_MW         <= (legal && memReadEnable_EM) ? mem_rdata : 16'h0000;
         PC2_MW             <= PC2_EM;
         regWriteDataSel_MW <= regWriteDataSel_EM;
         regWriteNum_MW     <= regWriteNum_EM;
         regWriteEnable_MW  <= regWriteEnable_EM & ~illegal;
         halt_MW            <= halt_EM & ~nop_EM;
         nop_MW             <= nop_EM;
         err_MW             <= illegal;
      end else if (stall_int) begin
         ALUOut_MW          <= 16'h0000;
         memData_MW         <= 16'h0000;
         PC2_MW             <= 16'h0000;
         regWriteDataSel_MW <= 2'b00;
         regWriteNum_MW     <= 3'b000;
         regWriteEnable_MW  <= 1'b0;
         halt_MW            <= 1'b0;
         nop_MW             <= 1'b1;
         err_MW             <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage_ctl.sv
// tb_mem_stage_ctl: directed-vector bench for mem_stage_ctl.
module tb_mem_stage_ctl;

   logic        clk;
   logic        rst;
   logic [15:0] ALUOut_EM;
   logic [15:0] R2Data_EM;
   logic        memReadEnable_EM;
   logic        memWriteEnable_EM;
   logic [1:0]  regWriteDataSel_EM;
   logic [2:0]  regWriteNum_EM;
   logic        regWriteEnable_EM;
   logic [15:0] PC2_EM;
   logic        halt_EM;
   logic        nop_EM;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        mem_stall;
   logic        stall_out;
   logic [15:0] ALUOut_MW;
   logic [15:0] memData_MW;
   logic [15:0] PC2_MW;
   logic [1:0]  regWriteDataSel_MW;
   logic [2:0]  regWriteNum_MW;
   logic        regWriteEnable_MW;
   logic        halt_MW;
   logic        nop_MW;
   logic        err_MW;

   int vectorCount = 0;
   int missCount   = 0;

   mem_stage_ctl dut (
      .clk                (clk),
      .rst                (rst),
      .ALUOut_EM          (ALUOut_EM),
      .R2Data_EM          (R2Data_EM),
      .memReadEnable_EM   (memReadEnable_EM),
      .memWriteEnable_EM  (memWriteEnable_EM),
      .regWriteDataSel_EM (regWriteDataSel_EM),
      .regWriteNum_EM     (regWriteNum_EM),
      .regWriteEnable_EM  (regWriteEnable_EM),
      .PC2_EM             (PC2_EM),
      .halt_EM            (halt_EM),
      .nop_EM             (nop_EM),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rd             (mem_rd),
      .mem_wr             (mem_wr),
      .mem_rdata          (mem_rdata),
      .mem_done           (mem_done),
      .mem_stall          (mem_stall),
      .stall_out          (stall_out),
      .ALUOut_MW          (ALUOut_MW),
      .memData_MW         (memData_MW),
      .PC2_MW             (PC2_MW),
      .regWriteDataSel_MW (regWriteDataSel_MW),
      .regWriteNum_MW     (regWriteNum_MW),
      .regWriteEnable_MW  (regWriteEnable_MW),
      .halt_MW            (halt_MW),
      .nop_MW             (nop_MW),
      .err_MW             (err_MW)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectorCount++;
      assert (observed === expected)
      else begin
         missCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBit(input string tag, input logic observed, input logic expected);
      vectorCount++;
      assert (observed === expected)
      else begin
         missCount++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] wdata,
                                input logic rdEn, input logic wrEn, input logic rwe,
                                input logic [2:0] rnum, input logic halt);
      ALUOut_EM          = addr;
      R2Data_EM          = wdata;
      memReadEnable_EM   = rdEn;
      memWriteEnable_EM  = wrEn;
      regWriteEnable_EM  = rwe;
      regWriteNum_EM     = rnum;
      halt_EM            = halt;
      regWriteDataSel_EM = 2'd1;
      PC2_EM             = addr + 16'd2;
      nop_EM             = 1'b0;
      #1;
   endtask

   // Directed sequence covering reset, ALU op, hit, miss, busy memory,
   // misaligned access, halt, and reset while waiting.
   initial begin
      rst = 1'b1;
      ALUOut_EM = 16'h0; R2Data_EM = 16'h0; memReadEnable_EM = 1'b0; memWriteEnable_EM = 1'b0;
      regWriteDataSel_EM = 2'd0; regWriteNum_EM = 3'd0; regWriteEnable_EM = 1'b0; PC2_EM = 16'h0;
      halt_EM = 1'b0; nop_EM = 1'b0; mem_rdata = 16'h0; mem_done = 1'b0; mem_stall = 1'b0;
      tick();
      tick();
      checkBit("rst_nop", nop_MW, 1'b1);
      checkBit("rst_stall", stall_out, 1'b0);
      checkBit("rst_halt", halt_MW, 1'b0);
      checkOutput("rst_alu", ALUOut_MW, 16'h0000);
      rst = 1'b0;

      // ALU op
      applyStimulus(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
      checkBit("alu_stall", stall_out, 1'b0);
      tick();
      checkOutput("alu_out", ALUOut_MW, 16'h1234);
      checkBit("alu_rwe", regWriteEnable_MW, 1'b1);
      checkOutput("alu_rnum", {13'd0, regWriteNum_MW}, 16'd3);
      checkOutput("alu_pc2", PC2_MW, 16'h1236);
      checkBit("alu_nop", nop_MW, 1'b0);

      // Load hit
      applyStimulus(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
      mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
      checkBit("hit_rd", mem_rd, 1'b1);
      checkBit("hit_stall", stall_out, 1'b0);
      checkOutput("hit_addr", mem_addr, 16'h0040);
      tick();
      mem_done = 1'b0; mem_rdata = 16'h0;
      checkOutput("hit_data", memData_MW, 16'hBEEF);
      checkOutput("hit_rnum", {13'd0, regWriteNum_MW}, 16'd5);

      // Store miss: done 3 cycles after request
      applyStimulus(16'h0100, 16'hCAFE, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
      checkBit("st_wr_c0", mem_wr, 1'b1);
      checkBit("st_stall_c0", stall_out, 1'b1);
      checkOutput("st_wdata", mem_wdata, 16'hCAFE);
      tick();
      checkBit("st_bubble1", nop_MW, 1'b1);
      checkBit("st_wr_c1", mem_wr, 1'b0);
      checkBit("st_stall_c1", stall_out, 1'b1);
      tick();
      checkBit("st_bubble2", nop_MW, 1'b1);
      checkBit("st_stall_c2", stall_out, 1'b1);
      tick();
      checkBit("st_bubble3", nop_MW, 1'b1);
      checkBit("st_bubble3_rwe", regWriteEnable_MW, 1'b0);
      mem_done = 1'b1; #1;
      checkBit("st_stall_c3", stall_out, 1'b0);
      checkBit("st_wr_c3", mem_wr, 1'b0);
      tick();
      mem_done = 1'b0;
      checkBit("st_retire_nop", nop_MW, 1'b0);
      checkOutput("st_retire_alu", ALUOut_MW, 16'h0100);
      checkOutput("st_retire_data", memData_MW, 16'h0000);

      // Memory busy for two cycles, then load
      applyStimulus(16'h0002, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
      mem_stall = 1'b1; #1;
      checkBit("busy_rd1", mem_rd, 1'b0);
      checkBit("busy_stall1", stall_out, 1'b1);
      tick();
      checkBit("busy_bubble1", nop_MW, 1'b1);
      checkBit("busy_rd2", mem_rd, 1'b0);
      checkBit("busy_stall2", stall_out, 1'b1);
      tick();
      mem_stall = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555; #1;
      checkBit("busy_rd3", mem_rd, 1'b1);
      checkBit("busy_stall3", stall_out, 1'b0);
      tick();
      mem_done = 1'b0;
      checkOutput("busy_data", memData_MW, 16'h5555);

      // Misaligned load
      applyStimulus(16'h0003, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
      checkBit("mis_rd", mem_rd, 1'b0);
      checkBit("mis_stall", stall_out, 1'b0);
      tick();
      checkBit("mis_err", err_MW, 1'b1);
      checkBit("mis_rwe", regWriteEnable_MW, 1'b0);
      checkOutput("mis_data", memData_MW, 16'h0000);

      // Halt, then loads are ignored
      applyStimulus(16'h0777, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      checkBit("halt_stall", stall_out, 1'b0);
      tick();
      checkBit("halt_set", halt_MW, 1'b1);
      applyStimulus(16'h0010, 16'h0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
      mem_done = 1'b1; mem_rdata = 16'h1111; #1;
      checkBit("halted_rd", mem_rd, 1'b0);
      checkBit("halted_stall", stall_out, 1'b0);
      tick();
      checkBit("halted_hold", halt_MW, 1'b1);
      checkOutput("halted_alu", ALUOut_MW, 16'h0777);
      checkOutput("halted_data", memData_MW, 16'h0000);
      mem_done = 1'b0;

      // Reset out of HALTED, then reset in the middle of a miss
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0);
      checkBit("wrst_rd", mem_rd, 1'b1);
      checkBit("wrst_stall", stall_out, 1'b1);
      tick();
      checkBit("wrst_wait_rd", mem_rd, 1'b0);
      rst = 1'b1; mem_done = 1'b1; mem_rdata = 16'h9999; #1;
      checkBit("wrst_rst_rd", mem_rd, 1'b0);
      checkBit("wrst_rst_stall", stall_out, 1'b0);
      tick();
      checkBit("wrst_nop", nop_MW, 1'b1);
      checkOutput("wrst_data", memData_MW, 16'h0000);
      checkBit("wrst_err", err_MW, 1'b0);
      checkBit("wrst_halt", halt_MW, 1'b0);
      rst = 1'b0;
      applyStimulus(16'h00AA, 16'h0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
      checkBit("post_stall", stall_out, 1'b0);
      checkBit("post_rd", mem_rd, 1'b0);
      tick();
      mem_done = 1'b0;
      checkOutput("post_alu", ALUOut_MW, 16'h00AA);
      checkBit("post_rwe", regWriteEnable_MW, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctl.md
# mem_stage_ctl

Memory-stage controller and MEM/WB pipeline register for the 16-bit five-stage pipeline. It consumes the registered EX/MEM outputs and issues single-cycle read/write requests to a variable-latency data memory (cache-style done/stall handshake). It stalls the upstream pipeline while an access is outstanding and registers the retired instruction into the MEM/WB fields consumed by writeback.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ALUOut_EM  in  16  effective address / ALU result
- R2Data_EM  in  16  store data
- memReadEnable_EM, memWriteEnable_EM  in  1 each  load / store
- regWriteDataSel_EM  in  2  writeback mux select (passed through)
- regWriteNum_EM  in  3  destination register
- regWriteEnable_EM  in  1  register write enable
- PC2_EM  in  16  PC+2 (passed through)
- halt_EM, nop_EM  in  1 each  halt / bubble marker
- mem_addr  out  16  = ALUOut_EM
- mem_wdata  out  16  = R2Data_EM
- mem_rd, mem_wr  out  1 each  request strobes, one cycle per access
- mem_rdata  in  16  read data, valid with mem_done
- mem_done  in  1  access complete (may assert in the request cycle)
- mem_stall  in  1  memory busy; request not accepted this cycle
- stall_out  out  1  freeze EX/MEM and earlier stages
- ALUOut_MW, memData_MW, PC2_MW  out  16 each
- regWriteDataSel_MW  out  2;  regWriteNum_MW  out  3
- regWriteEnable_MW, halt_MW, nop_MW, err_MW  out  1 each

## Operation
- States: IDLE, WAIT, HALTED. Reset -> IDLE.
- Access = (memReadEnable_EM | memWriteEnable_EM) & ~nop_EM & ~halt_EM.
- Illegal = access & (ALUOut_EM[0] | (memReadEnable_EM & memWriteEnable_EM)). No request is issued. Retire immediately with err_MW=1 and regWriteEnable_MW=0.
- IDLE, no access: retire same cycle, stall_out=0.
- IDLE, legal access, mem_stall=1: no strobe; stall_out=1; stay IDLE; retry next cycle.
- IDLE, legal access, mem_stall=0: assert mem_rd or mem_wr for exactly this cycle.
  - If mem_done is also high: retire now, stall_out=0.
  - Otherwise: stall_out=1 and go to WAIT.
- WAIT: strobes held 0; stall_out=1 until mem_done. On mem_done: retire, stall_out=0, go to IDLE.
- Retire means MEM/WB loads the EX/MEM fields.
  - memData_MW = mem_rdata for loads, 0 otherwise.
  - err_MW = illegal.
- Any cycle with stall_out=1 loads a bubble into MEM/WB: nop_MW=1, regWriteEnable_MW=0, halt_MW=0, err_MW=0, other fields 0. This prevents a double writeback.
- Halt: retiring halt_EM=1 sets halt_MW=1 and moves to HALTED.
  - HALTED: no strobes, stall_out=0, halt_MW held 1, other MEM/WB fields held. Exit only by rst.
- mem_done while in IDLE without a same-cycle request is ignored.

## Timing
- Reset values: every output 0 except nop_MW=1. State = IDLE.
- Hit latency: 0 stall cycles; the result is visible on the MEM/WB outputs the cycle after the request.
- Miss latency: N stall cycles, where N = cycles from request to mem_done.
- mem_addr and mem_wdata are combinational from the EX/MEM inputs. They are stable during stalls because EX/MEM is frozen.
- stall_out is combinational from state, access, mem_stall and mem_done (Mealy); it must not depend on stall_out itself.
- rst during WAIT: return to IDLE with no strobe that cycle. A late mem_done is ignored.

## Test plan
- ALU op, ALUOut_EM=16'h1234, regWriteEnable_EM=1, rd=3 -> next cycle ALUOut_MW=16'h1234, regWriteEnable_MW=1, regWriteNum_MW=3, stall_out never high.
- Load from 16'h0040, mem_done in the request cycle, mem_rdata=16'hBEEF -> mem_rd high 1 cycle, no stall, next cycle memData_MW=16'hBEEF.
- Store to 16'h0100, mem_done 3 cycles after request -> mem_wr high exactly 1 cycle, stall_out high 3 cycles, 3 bubbles (nop_MW=1, regWriteEnable_MW=0), then the store retires.
- mem_stall=1 for 2 cycles, then a load to 16'h0002 -> no strobe for 2 cycles, stall_out=1, single mem_rd on cycle 3.
- Load to 16'h0003 -> no strobe, err_MW=1 next cycle, regWriteEnable_MW=0.
- halt_EM=1 retires, then loads presented -> halt_MW stuck at 1, no strobes. Assert rst mid-WAIT on a later run -> all outputs at reset values next cycle, state IDLE.
